// File: rtl/ebus_diag_reader.sv
// EBUS diagnostic-read master: issues DIAG function 12x for one or all eight EDP
// sources, waits out the settle window, captures EBUS and returns it with parity.
module ebus_diag_reader #(
    parameter int SETTLE_CYCLES = 2,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic        eboxClk,
    input  logic        eboxReset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [2:0]  reqSel,
    input  logic        reqBurst,
    output logic        ebusReq,
    input  logic        ebusGrant,
    output logic [8:0]  diagFunc,
    output logic        diagReadFunc12X,
    input  logic [0:35] EBUS,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [0:35] rspData,
    output logic [2:0]  rspSel,
    output logic        rspParity,
    output logic        rspLast,
    output logic        rspError
);

    localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(GRANT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARB, DRIVE, RESP} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  sel_reg, sel_next;
    logic        burst_reg, burst_next;
    logic [3:0]  settle_reg, settle_next;
    logic [7:0]  timer_reg, timer_next;
    logic        ready_reg;
    logic [0:35] data_reg, data_next;
    logic [2:0]  rsp_sel_reg, rsp_sel_next;
    logic        parity_reg, parity_next;
    logic        last_reg, last_next;
    logic        error_reg, error_next;
    logic        accept;

    assign accept = reqValid && ready_reg;

    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            state_reg   <= IDLE;
            sel_reg     <= '0;
            burst_reg   <= 1'b0;
            settle_reg  <= '0;
            timer_reg   <= '0;
            ready_reg   <= 1'b0;
            data_reg    <= '0;
            rsp_sel_reg <= '0;
            parity_reg  <= 1'b0;
            last_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            burst_reg   <= burst_next;
            settle_reg  <= settle_next;
            timer_reg   <= timer_next;
            ready_reg   <= (state_next == IDLE);
            data_reg    <= data_next;
            rsp_sel_reg <= rsp_sel_next;
            parity_reg  <= parity_next;
            last_reg    <= last_next;
            error_reg   <= error_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        burst_next   = burst_reg;
        settle_next  = settle_reg;
        timer_next   = timer_reg;
        data_next    = data_reg;
        rsp_sel_next = rsp_sel_reg;
        parity_next  = parity_reg;
        last_next    = last_reg;
        error_next   = error_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    sel_next    = reqBurst ? 3'd0 : reqSel;
                    burst_next  = reqBurst;
                    timer_next  = '0;
                    settle_next = '0;
                    state_next  = ARB;
                end
            end
            ARB: begin
                if (ebusGrant) begin
                    settle_next = '0;
                    timer_next  = '0;
                    state_next  = DRIVE;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    data_next    = '0;
                    parity_next  = 1'b0;
                    rsp_sel_next = sel_reg;
                    last_next    = 1'b1;
                    error_next   = 1'b1;
                    burst_next   = 1'b0;
                    state_next   = RESP;
                end else begin
                    timer_next = timer_reg + 8'd1;
                end
            end
            DRIVE: begin
                // A grant drop restarts settling; a long drop times out like ARB.
                if (!ebusGrant) begin
                    settle_next = '0;
                    if (timer_reg == TIMEOUT_LAST) begin
                        data_next    = '0;
                        parity_next  = 1'b0;
                        rsp_sel_next = sel_reg;
                        last_next    = 1'b1;
                        error_next   = 1'b1;
                        burst_next   = 1'b0;
                        state_next   = RESP;
                    end else begin
                        timer_next = timer_reg + 8'd1;
                    end
                end else begin
                    timer_next = '0;
                    if (settle_reg == SETTLE_LAST) begin
                        data_next    = EBUS;
                        parity_next  = ^EBUS;
                        rsp_sel_next = sel_reg;
                        last_next    = !burst_reg || (sel_reg == 3'd7);
                        error_next   = 1'b0;
                        state_next   = RESP;
                    end else begin
                        settle_next = settle_reg + 4'd1;
                    end
                end
            end
            RESP: begin
                if (rspReady) begin
                    if (last_reg) begin
                        state_next = IDLE;
                    end else begin
                        sel_next    = sel_reg + 3'd1;
                        timer_next  = '0;
                        settle_next = '0;
                        state_next  = ebusGrant ? DRIVE : ARB;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign reqReady        = ready_reg;
    assign ebusReq         = (state_reg == ARB) || (state_reg == DRIVE) ||
                             ((state_reg == RESP) && burst_reg && (sel_reg != 3'd7));
    assign diagReadFunc12X = (state_reg == DRIVE);
    assign diagFunc        = (state_reg == DRIVE) ? {3'b001, 3'b010, sel_reg} : 9'd0;
    assign rspValid        = (state_reg == RESP);
    assign rspData         = data_reg;
    assign rspSel          = rsp_sel_reg;
    assign rspParity       = parity_reg;
    assign rspLast         = last_reg;
    assign rspError        = error_reg;

endmodule

// File: tb/tb_ebus_diag_reader.sv
// Directed bench for ebus_diag_reader: single-read vector table plus burst,
// backpressure, grant timeout, grant drop and reset-in-DRIVE sequences.
module tb_ebus_diag_reader;

    localparam int SETTLE = 2;
    localparam int TMO    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_burst = 1'b0;
    logic [2:0]  req_sel = 3'd0;
    logic        ebus_grant = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        edp_mode = 1'b0;
    logic [0:35] ebus_val = '0;
    logic [0:35] ebus;

    logic        req_ready, ebus_req, diag_read, rsp_valid, rsp_parity, rsp_last, rsp_error;
    logic [8:0]  diag_func;
    logic [0:35] rsp_data;
    logic [2:0]  rsp_sel;

    int checks = 0;
    int errors = 0;

    // In EDP mode the bus returns the selected source index, like a real EDP mux.
    assign ebus = edp_mode ? {33'b0, diag_func[2:0]} : ebus_val;

    always #5 clk = ~clk;

    ebus_diag_reader #(.SETTLE_CYCLES(SETTLE), .GRANT_TIMEOUT(TMO)) dut (
        .eboxClk(clk), .eboxReset(rst),
        .reqValid(req_valid), .reqReady(req_ready), .reqSel(req_sel), .reqBurst(req_burst),
        .ebusReq(ebus_req), .ebusGrant(ebus_grant),
        .diagFunc(diag_func), .diagReadFunc12X(diag_read), .EBUS(ebus),
        .rspValid(rsp_valid), .rspReady(rsp_ready), .rspData(rsp_data), .rspSel(rsp_sel),
        .rspParity(rsp_parity), .rspLast(rsp_last), .rspError(rsp_error)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [0:35] ebus;
        logic [8:0]  func;
        logic [0:35] data;
        logic        parity;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [2:0] sel, input logic burst);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_req", 64'(req_ready), 64'd1);
        req_sel   = sel;
        req_burst = burst;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        $display("request sel=%0d burst=%0d issued", sel, burst);
    endtask

    task automatic wait_rsp(input logic [8:0] func, output int n, output int drive_cycles);
        n = 1;
        drive_cycles = 0;
        while (!rsp_valid && n < 60) begin
            if (diag_read && diag_func == func) drive_cycles++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n, dc, k, guard, arb;
        logic done;
        logic [0:35] held;

        vecs[0] = '{sel: 3'd3, ebus: 36'o123456701234, func: 9'o123, data: 36'o123456701234, parity: 1'b1};
        vecs[1] = '{sel: 3'd0, ebus: 36'o000000000000, func: 9'o120, data: 36'o000000000000, parity: 1'b0};
        vecs[2] = '{sel: 3'd7, ebus: 36'o777777777777, func: 9'o127, data: 36'o777777777777, parity: 1'b0};
        vecs[3] = '{sel: 3'd1, ebus: 36'o400000000003, func: 9'o121, data: 36'o400000000003, parity: 1'b1};
        vecs[4] = '{sel: 3'd5, ebus: 36'o000000000001, func: 9'o125, data: 36'o000000000001, parity: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_ebus_req", 64'(ebus_req), 64'd0);
        chk("rst_diag_func", 64'(diag_func), 64'd0);
        chk("rst_diag_read", 64'(diag_read), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_sel", 64'(rsp_sel), 64'd0);
        chk("rst_rsp_parity", 64'(rsp_parity), 64'd0);
        chk("rst_rsp_last", 64'(rsp_last), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        // Single reads with grant held high
        ebus_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ebus_val = vecs[i].ebus;
            start_req(vecs[i].sel, 1'b0);
            wait_rsp(vecs[i].func, n, dc);
            chk("single_latency", 64'(n), 64'(2 + SETTLE));
            chk("single_func_cycles", 64'(dc), 64'(SETTLE));
            chk("single_data", 64'(rsp_data), 64'(vecs[i].data));
            chk("single_sel", 64'(rsp_sel), 64'(vecs[i].sel));
            chk("single_parity", 64'(rsp_parity), 64'(vecs[i].parity));
            chk("single_last", 64'(rsp_last), 64'd1);
            chk("single_error", 64'(rsp_error), 64'd0);
            $display("single sel=%0d data=%o parity=%0d latency=%0d", rsp_sel, rsp_data, rsp_parity, n);
            handshake();
            chk("single_valid_drop", 64'(rsp_valid), 64'd0);
            chk("single_ready_back", 64'(req_ready), 64'd1);
        end

        // Burst over all eight sources
        edp_mode  = 1'b1;
        rsp_ready = 1'b1;
        start_req(3'd5, 1'b1);
        k = 0;
        guard = 0;
        done = 1'b0;
        while (!done && guard < 200) begin
            if (diag_read) chk("burst_func", 64'(diag_func), 64'(9'o120 + 9'(k)));
            if (rsp_valid) begin
                chk("burst_sel", 64'(rsp_sel), 64'(k));
                chk("burst_data", 64'(rsp_data), 64'(k));
                chk("burst_last", 64'(rsp_last), 64'(k == 7));
                chk("burst_req_held", 64'(ebus_req), 64'(k != 7));
                chk("burst_error", 64'(rsp_error), 64'd0);
                $display("burst sel=%0d data=%o last=%0d", rsp_sel, rsp_data, rsp_last);
                if (rsp_last) done = 1'b1;
                k++;
            end
            if (!done) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("burst_count", 64'(k), 64'd8);
        @(negedge clk);
        rsp_ready = 1'b0;
        edp_mode  = 1'b0;
        chk("burst_idle_ready", 64'(req_ready), 64'd1);
        chk("burst_idle_req", 64'(ebus_req), 64'd0);

        // Backpressure: response held, extra request ignored
        ebus_val = 36'o555000333111;
        start_req(3'd2, 1'b0);
        wait_rsp(9'o122, n, dc);
        held = rsp_data;
        chk("bp_data", 64'(held), 64'o555000333111);
        ebus_val  = 36'o000111222333;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(rsp_valid), 64'd1);
            chk("bp_data_hold", 64'(rsp_data), 64'o555000333111);
            chk("bp_no_accept", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        $display("backpressure held data=%o for 5 cycles", rsp_data);
        handshake();
        chk("bp_ready_after", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("bp_not_queued", 64'(ebus_req), 64'd0);

        // Grant never arrives
        ebus_grant = 1'b0;
        ebus_val   = 36'o777;
        start_req(3'd5, 1'b0);
        n = 1;
        arb = 0;
        while (!rsp_valid && n < 60) begin
            if (ebus_req) arb++;
            @(negedge clk);
            n++;
        end
        chk("tmo_arb_cycles", 64'(arb), 64'(TMO));
        chk("tmo_valid", 64'(rsp_valid), 64'd1);
        chk("tmo_error", 64'(rsp_error), 64'd1);
        chk("tmo_data", 64'(rsp_data), 64'd0);
        chk("tmo_last", 64'(rsp_last), 64'd1);
        chk("tmo_parity", 64'(rsp_parity), 64'd0);
        $display("timeout error=%0d after %0d arb cycles", rsp_error, arb);
        handshake();
        chk("tmo_idle", 64'(req_ready), 64'd1);

        // Grant drops for one cycle in DRIVE
        ebus_grant = 1'b1;
        ebus_val   = 36'o111111111111;
        start_req(3'd6, 1'b0);
        @(negedge clk);
        chk("drop_in_drive", 64'(diag_read), 64'd1);
        ebus_grant = 1'b0;
        @(negedge clk);
        chk("drop_stays_drive", 64'(diag_read), 64'd1);
        ebus_grant = 1'b1;
        @(negedge clk);
        chk("drop_not_yet", 64'(rsp_valid), 64'd0);
        ebus_val = 36'o222222222222;
        @(negedge clk);
        chk("drop_valid", 64'(rsp_valid), 64'd1);
        chk("drop_data", 64'(rsp_data), 64'o222222222222);
        chk("drop_sel", 64'(rsp_sel), 64'd6);
        $display("grant drop sel=%0d data=%o", rsp_sel, rsp_data);
        handshake();

        // Reset while driving
        start_req(3'd4, 1'b0);
        @(negedge clk);
        chk("rstd_func_before", 64'(diag_func), 64'o124);
        rst = 1'b1;
        @(negedge clk);
        chk("rstd_diag_read", 64'(diag_read), 64'd0);
        chk("rstd_diag_func", 64'(diag_func), 64'd0);
        chk("rstd_ebus_req", 64'(ebus_req), 64'd0);
        chk("rstd_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstd_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstd_ready_after", 64'(req_ready), 64'd1);
        chk("rstd_valid_after", 64'(rsp_valid), 64'd0);
        $display("reset in drive: outputs cleared, ready=%0d", req_ready);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebus_diag_reader.md
Name: ebus_diag_reader

Overview:
- EBUS diagnostic-read master: the initiating end of the EDP diagnostic EBUS path.
- A front-end request selects one EDP source (AR, BR, MQ, FM, BRX, ARX, ADX, AD). The block issues DIAG function 12x, holds EDPdrivingEBUS-qualifying strobes through a settle window, captures EBUS, and returns the word with parity over a valid/ready handshake.
- Burst mode walks all eight sources in order, 0 through 7.

Parameters:
- SETTLE_CYCLES, 2, eboxClk cycles the function is held before EBUS is sampled; legal range 1–15.
- GRANT_TIMEOUT, 64, cycles to wait for ebusGrant before aborting with error; legal range 1–255.

Ports:
- eboxClk  in  1  sole clock; all state changes on rising edge.
- eboxReset  in  1  synchronous, active-high reset.
- reqValid  in  1  request strobe from front end.
- reqReady  out  1  block can accept a request (high only in IDLE).
- reqSel  in  3  source select, loaded into DIAG_FUNC[4:6].
- reqBurst  in  1  1 = read all eight sources; reqSel is ignored.
- ebusReq  out  1  request EBUS ownership.
- ebusGrant  in  1  EBUS ownership granted.
- diagFunc  out  9  DIAG function code; 0 when idle.
- diagReadFunc12X  out  1  high while a 12x read is being driven.
- EBUS  in  36  bus data, bit 0 = MSB.
- rspValid  out  1  response available.
- rspReady  in  1  front end accepts the response.
- rspData  out  36  captured word.
- rspSel  out  3  source the word came from.
- rspParity  out  1  XOR reduction of rspData.
- rspLast  out  1  final response of a request (always 1 for single reads).
- rspError  out  1  grant timeout; rspData = 0.

Behaviour:
- Reset values: reqReady=0 during reset and 1 the first cycle after. All other outputs are 0: ebusReq, diagFunc, diagReadFunc12X, rspValid, rspData, rspSel, rspParity, rspLast, rspError. The FSM is in IDLE and the counters are 0.
- IDLE:
  - reqReady=1.
  - Accept when reqValid & reqReady. Latch curSel = reqBurst ? 0 : reqSel and burst = reqBurst.
  - Move to ARB and assert ebusReq the next cycle.
- ARB:
  - ebusReq=1; grant timer counts up each cycle.
  - ebusGrant=1 → DRIVE with the settle counter cleared.
  - Timer reaches GRANT_TIMEOUT without grant → RESP with rspError=1, rspLast=1, rspData=0; burst is abandoned.
- DRIVE:
  - ebusReq=1, diagReadFunc12X=1, diagFunc = {3'b001, 3'b010, curSel} (octal 120+sel).
  - Settle counter increments each cycle. On the cycle it equals SETTLE_CYCLES-1, sample EBUS into rspData, set rspSel=curSel, and go to RESP.
  - Loss of ebusGrant during DRIVE restarts the settle count. The block stays in DRIVE, and the grant timer resumes from 0.
- RESP:
  - diagReadFunc12X=0 and diagFunc=0. ebusReq is held only if burst and curSel<7.
  - rspValid=1. rspLast = !burst | (curSel==7) | rspError.
  - rspData, rspSel, rspParity and rspLast are stable while rspValid & !rspReady.
  - On rspValid & rspReady:
    - if rspLast, go to IDLE;
    - otherwise curSel++ and go to ARB, or go directly to DRIVE if ebusGrant is still high.
- Latency: a single read with grant already high gives request accept → rspValid = 2 + SETTLE_CYCLES cycles.
- Request path: reqValid while not in IDLE is ignored, and nothing is queued.
- rspParity is registered together with rspData. Parity is odd-count → 1.
- Reset mid-operation: the FSM returns to IDLE and all outputs return to their reset values on the next edge. A pending response is dropped and the front end must reissue.
- curSel 3-bit increment never wraps in burst, because termination is at 7.

Test Plan:
- Single read, grant tied high, reqSel=3, EBUS=36'o123456_701234, SETTLE_CYCLES=2:
  - diagFunc=9'o123 for 2 cycles;
  - rspValid 4 cycles after accept with rspData=36'o123456701234, rspSel=3, rspLast=1, rspParity matching the XOR.
- Burst, EBUS = 36'o0 + source index:
  - eight responses, rspSel 0..7, rspData 0..7;
  - rspLast only on sel 7; diagFunc sequence 120..127.
- Backpressure: rspReady held low for 5 cycles → rspValid stays 1 and the data is unchanged; the next read does not start until the handshake completes.
- Grant never asserted with GRANT_TIMEOUT=4 → after 4 cycles in ARB, rspError=1, rspData=0, rspLast=1; return to IDLE after the handshake.
- Grant dropped for 1 cycle mid-DRIVE → the settle count restarts and EBUS is sampled 2 cycles after grant returns.
- eboxReset asserted in DRIVE:
  - next cycle diagReadFunc12X=0, diagFunc=0, ebusReq=0, rspValid=0;
  - reqReady=1 the cycle after reset deasserts.
